// File: rtl/mem_bus_arbiter_pkg.sv
// Shared bus types, arbiter state encoding and defaults for the ibus/dbus to cbus arbiter.
package mem_bus_arbiter_pkg;

  localparam int DEFAULT_MAX_D_STREAK = 4;
  localparam int STREAK_W = 4;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [63:0] addr;
    logic [7:0]  strobe;
    logic [63:0] data;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;

  // The accepted transaction, already shaped as the cbus request it becomes.
  typedef struct packed {
    logic        is_write;
    logic [2:0]  size;
    logic [63:0] addr;
    logic [7:0]  strobe;
    logic [63:0] data;
  } hold_t;

  // Picks the 32-bit fetch word out of a 64-bit beat.
  function automatic logic [31:0] select_word(input logic [63:0] beat, input logic upper);
    return upper ? beat[63:32] : beat[31:0];
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_arb_grant.sv
// Combinational dbus-first priority select with a streak limit protecting instruction fetch.
module arb_grant
  import mem_bus_arbiter_pkg::*;
#(
  parameter int MAX_D_STREAK = DEFAULT_MAX_D_STREAK
) (
  input  logic                enable,
  input  logic                ireq_valid,
  input  logic                dreq_valid,
  input  logic [STREAK_W-1:0] streak,
  output logic                grant_i,
  output logic                grant_d
);

  logic streak_full;

  always_comb begin
    streak_full = (streak == STREAK_W'(MAX_D_STREAK));
    grant_d     = enable && dreq_valid && !(ireq_valid && streak_full);
    grant_i     = enable && ireq_valid && !grant_d;
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Serialises core ibus/dbus requests onto a single-beat cbus and routes each response
// back to the requester that issued it.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int MAX_D_STREAK = DEFAULT_MAX_D_STREAK
) (
  input  logic       clk,
  input  logic       rst,
  input  ibus_req_t  ireq,
  output ibus_resp_t iresp,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output cbus_req_t  oreq,
  input  cbus_resp_t oresp
);

  arb_state_t          state;
  arb_state_t          state_next;
  logic [STREAK_W-1:0] streak;
  hold_t               held;
  logic                grant_i;
  logic                grant_d;
  logic                idle;
  logic                done;

  // Qualifying with rst keeps addr_ok low while reset is held, not only after an edge.
  assign idle = (state == IDLE) && rst;

  arb_grant #(
    .MAX_D_STREAK(MAX_D_STREAK)
  ) u_grant (
    .enable    (idle),
    .ireq_valid(ireq.valid),
    .dreq_valid(dreq.valid),
    .streak    (streak),
    .grant_i   (grant_i),
    .grant_d   (grant_d)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    done       = 1'b0;
    iresp      = '0;
    dresp      = '0;
    oreq       = '0;
    unique case (state)
      IDLE: begin
        iresp.addr_ok = grant_i;
        dresp.addr_ok = grant_d;
        if (grant_d) begin
          state_next = BUSY_D;
        end else if (grant_i) begin
          state_next = BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        oreq.valid    = 1'b1;
        oreq.is_write = held.is_write;
        oreq.size     = held.size;
        oreq.addr     = held.addr;
        oreq.strobe   = held.strobe;
        oreq.data     = held.data;
        done          = oresp.ready && oresp.last;
        // The completion cycle returns to IDLE; the next grant waits one cycle.
        if (done) begin
          state_next = IDLE;
          if (state == BUSY_I) begin
            iresp.data_ok = 1'b1;
            iresp.data    = select_word(oresp.data, held.addr[2]);
          end else begin
            dresp.data_ok = 1'b1;
            dresp.data    = oresp.data;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      held <= '0;
    end else if (grant_d) begin
      held <= '{is_write: |dreq.strobe, size: dreq.size, addr: dreq.addr,
                strobe: dreq.strobe, data: dreq.data};
    end else if (grant_i) begin
      held <= '{is_write: 1'b0, size: MSIZE4, addr: ireq.addr,
                strobe: 8'h00, data: 64'h0};
    end
  end

  // Streak only grows while fetch is actually waiting behind data traffic.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      streak <= '0;
    end else if (grant_d && ireq.valid) begin
      if (streak != STREAK_W'(MAX_D_STREAK)) begin
        streak <= streak + STREAK_W'(1);
      end
    end else if (grant_i || grant_d) begin
      streak <= '0;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench: directed table and corner sequences, then random traffic against a model.
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  localparam int MAXD = 4;
  localparam int RAND_CYCLES = 600;

  logic       clk;
  logic       rst;
  ibus_req_t  ireq;
  ibus_resp_t iresp;
  dbus_req_t  dreq;
  dbus_resp_t dresp;
  cbus_req_t  oreq;
  cbus_resp_t oresp;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic rst_v;
    logic iv;
    logic dv;
    logic exp_iok;
    logic exp_dok;
  } vec_t;

  vec_t  vecs[5];
  byte   seen[11];
  string grantExp;
  int    nGrant;

  // Reference model state: who owns the bus, how many data grants in a row, held request.
  int          owner;
  int          streakM;
  logic [63:0] hAddr;
  logic [63:0] hData;
  logic [7:0]  hStrobe;
  logic [2:0]  hSize;
  logic        hWrite;
  logic        dWins;
  logic        iWins;
  logic        fin;

  mem_bus_arbiter #(
    .MAX_D_STREAK(MAXD)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .ireq (ireq),
    .iresp(iresp),
    .dreq (dreq),
    .dresp(dresp),
    .oreq (oreq),
    .oresp(oresp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic iv, input logic [63:0] ia,
                               input logic dv, input logic [63:0] da, input logic [2:0] ds,
                               input logic [7:0] dst, input logic [63:0] dd,
                               input logic rdy, input logic lst, input logic [63:0] rd);
    ireq.valid   = iv;
    ireq.addr    = ia;
    dreq.valid   = dv;
    dreq.addr    = da;
    dreq.size    = ds;
    dreq.strobe  = dst;
    dreq.data    = dd;
    oresp.ready  = rdy;
    oresp.last   = lst;
    oresp.data   = rd;
  endtask

  task automatic idleInputs();
    applyStimulus(1'b0, 64'h0, 1'b0, 64'h0, 3'd0, 8'h0, 64'h0, 1'b0, 1'b0, 64'h0);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic toSample();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    idleInputs();

    // Combinational grant table in IDLE with streak 0, first entry under reset.
    vecs[0] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    nextCycle();
    for (int v = 0; v < 5; v++) begin
      rst        = vecs[v].rst_v;
      ireq.valid = vecs[v].iv;
      dreq.valid = vecs[v].dv;
      #1;
      checkOutput($sformatf("tbl%0d_iaddr_ok", v), iresp.addr_ok, vecs[v].exp_iok);
      checkOutput($sformatf("tbl%0d_daddr_ok", v), dresp.addr_ok, vecs[v].exp_dok);
      checkOutput($sformatf("tbl%0d_ovalid", v), oreq.valid, 1'b0);
      checkOutput($sformatf("tbl%0d_data_ok", v), {iresp.data_ok, dresp.data_ok}, 2'b00);
    end
    idleInputs();
    nextCycle();

    // Single fetch with upper-word select.
    applyStimulus(1'b1, 64'h8000_0004, 1'b0, 64'h0, 3'd0, 8'h0, 64'h0, 1'b0, 1'b0, 64'h0);
    toSample();
    checkOutput("fetch_addr_ok", iresp.addr_ok, 1'b1);
    checkOutput("fetch_no_daddr_ok", dresp.addr_ok, 1'b0);
    nextCycle();
    idleInputs();
    toSample();
    checkOutput("fetch_ovalid", oreq.valid, 1'b1);
    checkOutput("fetch_size", oreq.size, 3'd2);
    checkOutput("fetch_is_write", oreq.is_write, 1'b0);
    checkOutput("fetch_addr", oreq.addr, 64'h8000_0004);
    checkOutput("fetch_no_addr_ok_busy", iresp.addr_ok, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 64'h0, 1'b0, 64'h0, 3'd0, 8'h0, 64'h0, 1'b1, 1'b1, 64'h1111_2222_3333_4444);
    toSample();
    checkOutput("fetch_data_ok", iresp.data_ok, 1'b1);
    checkOutput("fetch_data", iresp.data, 32'h1111_2222);
    nextCycle();
    idleInputs();
    toSample();
    checkOutput("fetch_after_data_ok", iresp.data_ok, 1'b0);
    checkOutput("fetch_after_ovalid", oreq.valid, 1'b0);
    nextCycle();

    // Store held stable across three not-ready cycles.
    applyStimulus(1'b0, 64'h0, 1'b1, 64'h8000_0010, 3'd2, 8'h0F, 64'hDEAD_BEEF, 1'b0, 1'b0, 64'h0);
    toSample();
    checkOutput("store_addr_ok", dresp.addr_ok, 1'b1);
    nextCycle();
    idleInputs();
    for (int k = 0; k < 3; k++) begin
      toSample();
      checkOutput($sformatf("store_w%0d_fields", k),
                  {oreq.valid, oreq.is_write, oreq.strobe, oreq.data[31:0]},
                  {1'b1, 1'b1, 8'h0F, 32'hDEAD_BEEF});
      checkOutput($sformatf("store_w%0d_addr", k), oreq.addr, 64'h8000_0010);
      checkOutput($sformatf("store_w%0d_no_data_ok", k), dresp.data_ok, 1'b0);
      nextCycle();
    end
    applyStimulus(1'b0, 64'h0, 1'b0, 64'h0, 3'd0, 8'h0, 64'h0, 1'b1, 1'b1, 64'hCAFE);
    toSample();
    checkOutput("store_data_ok", dresp.data_ok, 1'b1);
    nextCycle();
    idleInputs();
    toSample();
    checkOutput("store_single_data_ok", dresp.data_ok, 1'b0);
    nextCycle();

    // Simultaneous requests: data first, fetch in the IDLE cycle after completion.
    applyStimulus(1'b1, 64'h100, 1'b1, 64'h200, 3'd3, 8'h00, 64'h0, 1'b0, 1'b0, 64'h0);
    toSample();
    checkOutput("simul_d_first", {iresp.addr_ok, dresp.addr_ok}, 2'b01);
    nextCycle();
    applyStimulus(1'b1, 64'h100, 1'b0, 64'h0, 3'd0, 8'h0, 64'h0, 1'b1, 1'b1, 64'h55);
    toSample();
    checkOutput("simul_d_done", dresp.data_ok, 1'b1);
    checkOutput("simul_no_b2b_grant", iresp.addr_ok, 1'b0);
    checkOutput("simul_d_addr", oreq.addr, 64'h200);
    nextCycle();
    applyStimulus(1'b1, 64'h100, 1'b0, 64'h0, 3'd0, 8'h0, 64'h0, 1'b0, 1'b0, 64'h0);
    toSample();
    checkOutput("simul_i_grant", iresp.addr_ok, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 64'h0, 1'b0, 64'h0, 3'd0, 8'h0, 64'h0, 1'b1, 1'b1, 64'hAAAA_BBBB_CCCC_DDDD);
    toSample();
    checkOutput("simul_i_data", {iresp.data_ok, iresp.data}, {1'b1, 32'hCCCC_DDDD});
    nextCycle();
    idleInputs();

    // Starvation limit: both requesters always valid, memory always completes at once.
    grantExp = "DDDDIDDDDID";
    nGrant   = 0;
    applyStimulus(1'b1, 64'h1000, 1'b1, 64'h2000, 3'd3, 8'h00, 64'h0, 1'b1, 1'b1, 64'h0);
    for (int c = 0; c < 40 && nGrant < 11; c++) begin
      toSample();
      checkOutput("starve_one_grant", iresp.addr_ok & dresp.addr_ok, 1'b0);
      if (dresp.addr_ok) begin
        seen[nGrant] = "D";
        nGrant++;
      end else if (iresp.addr_ok) begin
        seen[nGrant] = "I";
        nGrant++;
      end
      if (nGrant < 11) nextCycle();
    end
    checkOutput("starve_grant_count", nGrant, 11);
    for (int k = 0; k < nGrant; k++) begin
      checkOutput($sformatf("starve_grant%0d", k), seen[k], grantExp[k]);
    end
    nextCycle();
    applyStimulus(1'b0, 64'h0, 1'b0, 64'h0, 3'd0, 8'h0, 64'h0, 1'b1, 1'b1, 64'h0);
    toSample();
    checkOutput("starve_tail_done", dresp.data_ok, 1'b1);
    nextCycle();
    idleInputs();

    // Multi-beat response: only the last beat completes.
    applyStimulus(1'b0, 64'h0, 1'b1, 64'h300, 3'd3, 8'hFF, 64'h77, 1'b0, 1'b0, 64'h0);
    toSample();
    checkOutput("mbeat_addr_ok", dresp.addr_ok, 1'b1);
    nextCycle();
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b0, 64'h0, 1'b0, 64'h0, 3'd0, 8'h0, 64'h0, 1'b1, 1'b0, 64'h1);
      toSample();
      checkOutput($sformatf("mbeat_beat%0d_no_ok", k), dresp.data_ok, 1'b0);
      nextCycle();
    end
    applyStimulus(1'b0, 64'h0, 1'b0, 64'h0, 3'd0, 8'h0, 64'h0, 1'b1, 1'b1, 64'h99);
    toSample();
    checkOutput("mbeat_last_ok", {dresp.data_ok, dresp.data}, {1'b1, 64'h99});
    nextCycle();
    idleInputs();

    // Reset mid-transaction abandons the store.
    applyStimulus(1'b0, 64'h0, 1'b1, 64'h400, 3'd1, 8'h03, 64'h5, 1'b0, 1'b0, 64'h0);
    toSample();
    checkOutput("rstmid_addr_ok", dresp.addr_ok, 1'b1);
    nextCycle();
    idleInputs();
    toSample();
    checkOutput("rstmid_busy", oreq.valid, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("rstmid_ovalid_async", oreq.valid, 1'b0);
    checkOutput("rstmid_data_ok_async", dresp.data_ok, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(1'b0, 64'h0, 1'b0, 64'h0, 3'd0, 8'h0, 64'h0, 1'b1, 1'b1, 64'hF00D);
    for (int k = 0; k < 2; k++) begin
      nextCycle();
      toSample();
      checkOutput($sformatf("rstmid_after%0d", k),
                  {oreq.valid, dresp.data_ok, iresp.data_ok}, 3'b000);
    end
    nextCycle();
    idleInputs();

    // Random traffic against the transaction-level model, from a fresh reset.
    rst = 1'b0;
    #2;
    rst     = 1'b1;
    owner   = 0;
    streakM = 0;
    hAddr = '0; hData = '0; hStrobe = '0; hSize = '0; hWrite = 1'b0;
    for (int n = 0; n < RAND_CYCLES; n++) begin
      applyStimulus(($urandom_range(0, 1) == 1), {$urandom, $urandom},
                    ($urandom_range(0, 4) < 3), {$urandom, $urandom}, 3'($urandom_range(0, 7)),
                    ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'h00, {$urandom, $urandom},
                    ($urandom_range(0, 4) < 3), ($urandom_range(0, 4) < 3), {$urandom, $urandom});
      toSample();
      dWins = 1'b0;
      iWins = 1'b0;
      if (owner == 0) begin
        dWins = dreq.valid && !(ireq.valid && streakM >= MAXD);
        iWins = ireq.valid && !dWins;
      end
      fin = (owner != 0) && oresp.ready && oresp.last;
      checkOutput("rnd_iaddr_ok", iresp.addr_ok, iWins);
      checkOutput("rnd_daddr_ok", dresp.addr_ok, dWins);
      checkOutput("rnd_ovalid", oreq.valid, owner != 0);
      checkOutput("rnd_idata_ok", iresp.data_ok, fin && owner == 1);
      checkOutput("rnd_ddata_ok", dresp.data_ok, fin && owner == 2);
      if (owner != 0) begin
        checkOutput("rnd_oaddr", oreq.addr, hAddr);
        checkOutput("rnd_ofields", {oreq.is_write, oreq.size, oreq.strobe},
                    {hWrite, hSize, hStrobe});
        checkOutput("rnd_odata", oreq.data, hData);
      end
      if (fin && owner == 1) begin
        checkOutput("rnd_idata", iresp.data, hAddr[2] ? oresp.data[63:32] : oresp.data[31:0]);
      end
      if (fin && owner == 2) begin
        checkOutput("rnd_ddata", dresp.data, oresp.data);
      end
      if (dWins) begin
        owner   = 2;
        hAddr   = dreq.addr;
        hData   = dreq.data;
        hStrobe = dreq.strobe;
        hSize   = dreq.size;
        hWrite  = (dreq.strobe != 8'h00);
        streakM = ireq.valid ? ((streakM + 1 > MAXD) ? MAXD : streakM + 1) : 0;
      end else if (iWins) begin
        owner   = 1;
        hAddr   = ireq.addr;
        hData   = 64'h0;
        hStrobe = 8'h00;
        hSize   = 3'd2;
        hWrite  = 1'b0;
        streakM = 0;
      end else if (fin) begin
        owner = 0;
      end
      nextCycle();
    end
    idleInputs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
